// File: rtl/card_select_ctrl_pkg.sv
// card_select_ctrl_pkg
// Shared definitions for the card selection controller: the FSM state
// encoding, board geometry, the location/data widths and the position of
// the revealed flag inside a board word.
package card_select_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int REVEALED_BIT = 5;
  localparam int BOARD_DIM    = 4;
  localparam int LOC_W        = 4;
  localparam int DATA_W       = 6;
  localparam int BOARD_SIZE   = BOARD_DIM * BOARD_DIM;

endpackage

// File: rtl/card_select_ctrl_btn_edge.sv
// btn_edge
// Rising-edge detector for one debounced button level. The pulse is
// combinational so the controller acts in the same cycle the level first
// reads high; a held level produces no further pulses.
// Ports:
//   Clk   - system clock
//   Reset - synchronous, active-high; clears the level history
//   level - debounced button level
//   rise  - high for the single cycle where level goes 0 -> 1
module btn_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge Clk) begin
    if (Reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/card_select_ctrl.sv
// card_select_ctrl
// Cursor and selection front end for the memory-card game. Keeps a shadow
// copy of the 4x4 board, moves a cursor with the direction buttons and
// issues a selection request (Select/Ack handshake) for the card under the
// cursor when it is not already revealed.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   BtnU/BtnD/BtnL/BtnR   - cursor movement buttons (debounced levels)
//   BtnC                  - select button (debounced level)
//   WriteEnable/dataLoc/dataIn - board write port from gameplay_sm
//   Ack                   - gameplay_sm accepts the current selection
//   Select                - selection request
//   CardSelectLoc         - cursor location, row*4+col
//   CardSelectData        - board word captured for the current request
//   Busy                  - FSM not idle
//   Reject                - one-cycle pulse on refused / timed-out selection
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | cursor moves, waiting for a select press
// ST_REQ     | Select high, waiting for Ack or the timeout
// ST_RELEASE | request accepted, waiting for Ack to drop
module card_select_ctrl
  import card_select_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BtnU,
  input  logic              BtnD,
  input  logic              BtnL,
  input  logic              BtnR,
  input  logic              BtnC,
  input  logic              WriteEnable,
  input  logic [LOC_W-1:0]  dataLoc,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              Ack,
  output logic              Select,
  output logic [LOC_W-1:0]  CardSelectLoc,
  output logic [DATA_W-1:0] CardSelectData,
  output logic              Busy,
  output logic              Reject
);

  logic [DATA_W-1:0] board [BOARD_SIZE];
  logic [1:0]        row, col;
  logic [7:0]        timer;
  state_t            state;
  logic              up_e, dn_e, lf_e, rt_e, c_e;
  logic [DATA_W-1:0] sel_word;

  btn_edge u_edge_u (.Clk(Clk), .Reset(Reset), .level(BtnU), .rise(up_e));
  btn_edge u_edge_d (.Clk(Clk), .Reset(Reset), .level(BtnD), .rise(dn_e));
  btn_edge u_edge_l (.Clk(Clk), .Reset(Reset), .level(BtnL), .rise(lf_e));
  btn_edge u_edge_r (.Clk(Clk), .Reset(Reset), .level(BtnR), .rise(rt_e));
  btn_edge u_edge_c (.Clk(Clk), .Reset(Reset), .level(BtnC), .rise(c_e));

  assign CardSelectLoc = {row, col};

  // Shadow board follows every write regardless of FSM state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < BOARD_SIZE; i++) board[i] <= '0;
    end else if (WriteEnable) begin
      board[dataLoc] <= dataIn;
    end
  end

  // A write landing on the cursor in the press cycle wins over the stored word.
  always_comb begin
    sel_word = board[CardSelectLoc];
    if (WriteEnable && (dataLoc == CardSelectLoc)) sel_word = dataIn;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= ST_IDLE;
      row            <= 2'd0;
      col            <= 2'd0;
      Select         <= 1'b0;
      Busy           <= 1'b0;
      Reject         <= 1'b0;
      CardSelectData <= '0;
      timer          <= 8'd0;
    end else begin
      Reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Priority C > U > D > L > R; 2-bit row/col wrap mod 4 by themselves.
          if (c_e) begin
            if (sel_word[REVEALED_BIT]) begin
              Reject <= 1'b1;
            end else begin
              CardSelectData <= sel_word;
              Select         <= 1'b1;
              Busy           <= 1'b1;
              timer          <= 8'(ACK_TIMEOUT - 1);
              state          <= ST_REQ;
            end
          end else if (up_e) begin
            row <= row - 2'd1;
          end else if (dn_e) begin
            row <= row + 2'd1;
          end else if (lf_e) begin
            col <= col - 2'd1;
          end else if (rt_e) begin
            col <= col + 2'd1;
          end
        end
        ST_REQ: begin
          if (Ack) begin
            Select <= 1'b0;
            state  <= ST_RELEASE;
          end else if (timer == 8'd0) begin
            Select <= 1'b0;
            Busy   <= 1'b0;
            Reject <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ST_RELEASE: begin
          if (!Ack) begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          Select <= 1'b0;
          Busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_select_ctrl.sv
// tb_card_select_ctrl
// Directed bench for card_select_ctrl (ACK_TIMEOUT=4). Inputs change 1ns
// after the rising edge; outputs are sampled at the same point, so every
// check sees the state registered at the preceding edge.
module tb_card_select_ctrl;
  import card_select_ctrl_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset, BtnU, BtnD, BtnL, BtnR, BtnC, WriteEnable, Ack;
  logic [LOC_W-1:0]  dataLoc;
  logic [DATA_W-1:0] dataIn;
  logic              Select, Busy, Reject;
  logic [LOC_W-1:0]  CardSelectLoc;
  logic [DATA_W-1:0] CardSelectData;

  int checks = 0;
  int errors = 0;

  card_select_ctrl #(.ACK_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
    .WriteEnable(WriteEnable), .dataLoc(dataLoc), .dataIn(dataIn),
    .Ack(Ack), .Select(Select), .CardSelectLoc(CardSelectLoc),
    .CardSelectData(CardSelectData), .Busy(Busy), .Reject(Reject)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] loc, input logic [5:0] d);
    WriteEnable = 1'b1; dataLoc = loc; dataIn = d;
    tick();
    WriteEnable = 1'b0;
  endtask

  // 0:U 1:D 2:L 3:R 4:C
  task automatic press(input int b);
    case (b)
      0: BtnU = 1'b1;
      1: BtnD = 1'b1;
      2: BtnL = 1'b1;
      3: BtnR = 1'b1;
      default: BtnC = 1'b1;
    endcase
    tick();
    BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0; BtnC = 0;
    tick();
  endtask

  initial begin
    Reset = 1; BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0; BtnC = 0;
    WriteEnable = 0; Ack = 0; dataLoc = '0; dataIn = '0;
    tick(); tick();
    Reset = 0;
    check("rst_loc", 8'(CardSelectLoc), 8'd0);
    check("rst_sel", 8'(Select), 8'd0);
    check("rst_busy", 8'(Busy), 8'd0);
    check("rst_rej", 8'(Reject), 8'd0);
    check("rst_data", 8'(CardSelectData), 8'd0);

    // row wrap both ways
    press(0);
    check("up_wrap", 8'(CardSelectLoc), 8'd12);
    press(1);
    check("down_wrap", 8'(CardSelectLoc), 8'd0);

    for (int i = 0; i < 5; i++) press(3);
    press(1);
    check("r5_d1", 8'(CardSelectLoc), 8'd5);
    press(2);
    check("left", 8'(CardSelectLoc), 8'd4);
    press(2);
    check("left_wrap", 8'(CardSelectLoc), 8'd7);

    // held level: only one step
    BtnR = 1; tick(); tick(); tick(); BtnR = 0; tick();
    check("hold_norep", 8'(CardSelectLoc), 8'd4);
    press(3);
    check("back_to5", 8'(CardSelectLoc), 8'd5);

    // normal handshake
    wr(4'd5, 6'h0A);
    BtnC = 1; tick(); BtnC = 0;
    check("req_sel", 8'(Select), 8'd1);
    check("req_data", 8'(CardSelectData), 8'h0A);
    check("req_busy", 8'(Busy), 8'd1);
    BtnU = 1; tick(); BtnU = 0;
    check("busy_nomove", 8'(CardSelectLoc), 8'd5);
    check("req_hold", 8'(Select), 8'd1);
    Ack = 1; tick();
    check("ack_sel", 8'(Select), 8'd0);
    check("rel_busy", 8'(Busy), 8'd1);
    tick();
    check("rel_wait", 8'(Busy), 8'd1);
    Ack = 0; tick();
    check("idle_busy", 8'(Busy), 8'd0);
    check("no_rej", 8'(Reject), 8'd0);

    // revealed card refused
    wr(4'd5, 6'h2A);
    BtnC = 1; tick(); BtnC = 0;
    check("rev_rej", 8'(Reject), 8'd1);
    check("rev_sel", 8'(Select), 8'd0);
    check("rev_busy", 8'(Busy), 8'd0);
    tick();
    check("rev_rej_off", 8'(Reject), 8'd0);

    // timeout after exactly 4 cycles of Select
    wr(4'd5, 6'h0A);
    BtnC = 1; tick(); BtnC = 0;
    for (int i = 0; i < 4; i++) begin
      check("to_sel_hi", 8'(Select), 8'd1);
      check("to_rej_lo", 8'(Reject), 8'd0);
      tick();
    end
    check("to_sel_lo", 8'(Select), 8'd0);
    check("to_rej", 8'(Reject), 8'd1);
    check("to_busy", 8'(Busy), 8'd0);
    tick();
    check("to_rej_off", 8'(Reject), 8'd0);

    // write bypass in press cycle
    WriteEnable = 1; dataLoc = 4'd5; dataIn = 6'h21; BtnC = 1;
    tick();
    WriteEnable = 0; BtnC = 0;
    check("byp_rej", 8'(Reject), 8'd1);
    check("byp_sel", 8'(Select), 8'd0);
    tick();

    // U and C together: select wins
    wr(4'd5, 6'h0A);
    BtnU = 1; BtnC = 1; tick(); BtnU = 0; BtnC = 0;
    check("uc_sel", 8'(Select), 8'd1);
    check("uc_loc", 8'(CardSelectLoc), 8'd5);
    Ack = 1; tick(); Ack = 0; tick(); tick();
    check("uc_idle", 8'(Busy), 8'd0);

    // Ack in idle ignored
    Ack = 1; tick(); tick(); Ack = 0;
    check("idle_ack_busy", 8'(Busy), 8'd0);
    check("idle_ack_sel", 8'(Select), 8'd0);

    // reset mid-REQ, with a write to loc 0 colliding with reset
    wr(4'd0, 6'h25);
    BtnC = 1; tick(); BtnC = 0;
    check("pre_rst_sel", 8'(Select), 8'd1);
    Reset = 1; WriteEnable = 1; dataLoc = 4'd0; dataIn = 6'h3F;
    tick();
    Reset = 0; WriteEnable = 0;
    check("mid_rst_sel", 8'(Select), 8'd0);
    check("mid_rst_rej", 8'(Reject), 8'd0);
    check("mid_rst_loc", 8'(CardSelectLoc), 8'd0);
    check("mid_rst_busy", 8'(Busy), 8'd0);
    // loc 0 held 6'h25 before reset: a cleared board selects instead of rejecting
    BtnC = 1; tick(); BtnC = 0;
    check("clr_sel", 8'(Select), 8'd1);
    check("clr_rej", 8'(Reject), 8'd0);
    check("clr_data", 8'(CardSelectData), 8'd0);
    Ack = 1; tick(); Ack = 0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
